// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4-channel mux scan controller.
package mux_scan_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        OUTPUT = 2'd2
    } scan_state_t;

endpackage

// File: rtl/mux_scan_ctrl_dwell_counter.sv
// Dwell counter: counts 0..DWELL_CYCLES-1 while enabled, wraps on terminal count.
module dwell_counter #(
    parameter  int DWELL_CYCLES = 4,
    localparam int CNT_W        = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] count_q;

    assign tc = (count_q == CNT_W'(DWELL_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= tc ? '0 : count_q + 1'b1;
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps a 4x1 mux through all channels, holds each select for DWELL_CYCLES,
// captures the mux output per channel and hands the frame off with valid/ready.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DWELL_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cont,
    output logic              s0,
    output logic              s1,
    input  logic              y_in,
    output logic [NUM_CH-1:0] frame,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic              busy
);

    scan_state_t       state_q, state_d;
    logic [SEL_W-1:0]  ch_q;
    logic [NUM_CH-1:0] frame_q;
    logic              load_scan;
    logic              dwell_tc;
    logic              last_ch;

    assign last_ch = (ch_q == SEL_W'(NUM_CH - 1));

    dwell_counter #(
        .DWELL_CYCLES(DWELL_CYCLES)
    ) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .clear(load_scan),
        .en   (state_q == SCAN),
        .tc   (dwell_tc)
    );

    always_comb begin
        state_d     = state_q;
        load_scan   = 1'b0;
        {s1, s0}    = '0;
        frame_valid = 1'b0;
        busy        = 1'b1;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d   = SCAN;
                    load_scan = 1'b1;
                end
            end
            SCAN: begin
                {s1, s0} = ch_q;
                if (dwell_tc && last_ch) state_d = OUTPUT;
            end
            OUTPUT: begin
                frame_valid = 1'b1;
                // cont only matters at the handshake edge
                if (frame_ready) begin
                    if (cont) begin
                        state_d   = SCAN;
                        load_scan = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            if (load_scan) begin
                ch_q <= '0;
            end else if (state_q == SCAN && dwell_tc) begin
                frame_q[ch_q] <= y_in;
                if (!last_ch) ch_q <= ch_q + 1'b1;
            end
        end
    end

    assign frame = frame_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: a behavioural 4x1 mux closes the loop.
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, start2, cont, frame_ready;
    logic [3:0] d_in;
    logic       s0, s1, y_in, frame_valid, busy;
    logic       s0b, s1b, y_in2, frame_valid2, busy2;
    logic [3:0] frame, frame2;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    assign y_in  = d_in[{s1, s0}];
    assign y_in2 = d_in[{s1b, s0b}];

    mux_scan_ctrl #(.DWELL_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .cont(cont),
        .s0(s0), .s1(s1), .y_in(y_in), .frame(frame),
        .frame_valid(frame_valid), .frame_ready(frame_ready), .busy(busy)
    );

    mux_scan_ctrl #(.DWELL_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .cont(cont),
        .s0(s0b), .s1(s1b), .y_in(y_in2), .frame(frame2),
        .frame_valid(frame_valid2), .frame_ready(frame_ready), .busy(busy2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start2 = 1'b0; cont = 1'b0;
        frame_ready = 1'b0; d_in = 4'b0000;
        tick(); tick();
        checks++;
        if ({frame_valid, busy, s1, s0, frame} !== 8'h00) begin
            errors++;
            $display("FAIL reset: valid/busy/sel/frame got %b want 00000000",
                     {frame_valid, busy, s1, s0, frame});
        end
        checks++;
        if ({frame_valid2, busy2, frame2} !== 6'b0) begin
            errors++;
            $display("FAIL reset_d2: got %b want 000000", {frame_valid2, busy2, frame2});
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        d_in = 4'b1101; frame_ready = 1'b1; cont = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({s1, s0} !== 2'(i / 4) || frame_valid !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL basic_scan cyc %0d: sel=%b valid=%b busy=%b want sel=%0d valid=0 busy=1",
                         i, {s1, s0}, frame_valid, busy, i / 4);
            end
            tick();
        end
        checks++;
        if (frame_valid !== 1'b1 || frame !== 4'b1101 || {s1, s0} !== 2'b00) begin
            errors++;
            $display("FAIL basic_frame: valid=%b frame=%b sel=%b want 1 1101 00",
                     frame_valid, frame, {s1, s0});
        end
        tick();
        checks++;
        if (frame_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_oneshot: valid=%b busy=%b want 0 0", frame_valid, busy);
        end
    endtask

    task automatic test_hold();
        d_in = 4'b0110; frame_ready = 1'b0; cont = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        for (int i = 0; i < 10; i++) begin
            d_in = 4'(i);
            checks++;
            if (frame_valid !== 1'b1 || frame !== 4'b0110 || busy !== 1'b1 || {s1, s0} !== 2'b00) begin
                errors++;
                $display("FAIL hold cyc %0d: valid=%b frame=%b busy=%b sel=%b want 1 0110 1 00",
                         i, frame_valid, frame, busy, {s1, s0});
            end
            tick();
        end
        frame_ready = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: busy=%b valid=%b want 0 0", busy, frame_valid);
        end
    endtask

    task automatic test_cont();
        d_in = 4'b1101; frame_ready = 1'b0; cont = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        checks++;
        if (frame_valid !== 1'b1 || frame !== 4'b1101) begin
            errors++;
            $display("FAIL cont_first: valid=%b frame=%b want 1 1101", frame_valid, frame);
        end
        d_in = 4'b0101;
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        cont = 1'b0;  // mid-scan change: this scan still completes
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (frame_valid !== 1'b0 || busy !== 1'b1 || {s1, s0} !== 2'(i / 4)) begin
                errors++;
                $display("FAIL cont_rescan cyc %0d: valid=%b busy=%b sel=%b want 0 1 %0d",
                         i, frame_valid, busy, {s1, s0}, i / 4);
            end
            tick();
        end
        checks++;
        if (frame_valid !== 1'b1 || frame !== 4'b0101) begin
            errors++;
            $display("FAIL cont_second: valid=%b frame=%b want 1 0101", frame_valid, frame);
        end
        frame_ready = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL cont_stop: busy=%b want 0", busy);
        end
    endtask

    task automatic test_start_ignored();
        d_in = 4'b1001; frame_ready = 1'b0; cont = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            start = (i == 5);
            tick();
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (frame_valid !== 1'b1 || frame !== 4'b1001) begin
            errors++;
            $display("FAIL ign_frame: valid=%b frame=%b want 1 1001", frame_valid, frame);
        end
        frame_ready = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (busy !== 1'b0 || frame_valid !== 1'b0) begin
                errors++;
                $display("FAIL ign_idle cyc %0d: busy=%b valid=%b want 0 0", i, busy, frame_valid);
            end
            tick();
        end
    endtask

    task automatic test_rst_mid();
        d_in = 4'b1111; frame_ready = 1'b1; cont = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        checks++;
        if ({s1, s0} !== 2'b10 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: sel=%b busy=%b want 10 1", {s1, s0}, busy);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || frame !== 4'b0000 || frame_valid !== 1'b0 || {s1, s0} !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid: busy=%b frame=%b valid=%b sel=%b want 0 0000 0 00",
                     busy, frame, frame_valid, {s1, s0});
        end
        rst = 1'b0;
        start = 1'b1;
        d_in = 4'b1010;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || {s1, s0} !== 2'b00) begin
            errors++;
            $display("FAIL rst_restart: busy=%b sel=%b want 1 00", busy, {s1, s0});
        end
        for (int i = 0; i < 16; i++) tick();
        checks++;
        if (frame_valid !== 1'b1 || frame !== 4'b1010) begin
            errors++;
            $display("FAIL rst_frame: valid=%b frame=%b want 1 1010", frame_valid, frame);
        end
        tick();
    endtask

    task automatic test_dwell2();
        d_in = 4'b0011; frame_ready = 1'b1; cont = 1'b0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({s1b, s0b} !== 2'(i / 2) || frame_valid2 !== 1'b0) begin
                errors++;
                $display("FAIL d2_scan cyc %0d: sel=%b valid=%b want %0d 0",
                         i, {s1b, s0b}, frame_valid2, i / 2);
            end
            tick();
        end
        checks++;
        if (frame_valid2 !== 1'b1 || frame2 !== 4'b0011) begin
            errors++;
            $display("FAIL d2_frame: valid=%b frame=%b want 1 0011", frame_valid2, frame2);
        end
        tick();
        checks++;
        if (frame_valid2 !== 1'b0 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL d2_done: valid=%b busy=%b want 0 0", frame_valid2, busy2);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_cont();
        test_start_ignored();
        test_rst_mid();
        test_dwell2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
